// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the streaming multiply-accumulate engine: the control
// FSM state encoding, the default operand/run sizes and a helper that derives
// the default accumulator width from them.
// No ports (package).
// -----------------------------------------------------------------------------
package mac_pkg;

  // Control FSM states of mac_stream_acc.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } macState_t;

  localparam int DEFAULT_DATA_W  = 4;
  localparam int DEFAULT_ACC_LEN = 16;

  // Width that can hold ACC_LEN full-scale products without wrapping.
  function automatic int defaultAccW(input int dataW, input int accLen);
    return 2 * dataW + $clog2(accLen);
  endfunction

  localparam int DEFAULT_ACC_W = defaultAccW(DEFAULT_DATA_W, DEFAULT_ACC_LEN);

endpackage

// File: rtl/mac_stream_acc_if.sv
// -----------------------------------------------------------------------------
// mac_stream_acc_if
// Bundles the run control, the operand stream handshake and the result signals
// of mac_stream_acc.
//   go        sequencer -> MAC  start request
//   in_valid  sequencer -> MAC  operand pair present
//   A, B      sequencer -> MAC  operands (DATA_W bits)
//   in_ready  MAC -> sequencer  pair accepted this cycle when in_valid is high
//   busy      MAC -> sequencer  run in progress
//   out       MAC -> consumer   final sum (ACC_W bits), held between runs
//   done      MAC -> consumer   one-cycle pulse marking out as fresh
// Modports: master (operand sequencer side), slave (the MAC engine).
// -----------------------------------------------------------------------------
interface mac_stream_acc_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
);

  logic              go;
  logic              in_valid;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              in_ready;
  logic              busy;
  logic [ACC_W-1:0]  out;
  logic              done;

  modport master (
    output go, in_valid, A, B,
    input  in_ready, busy, out, done
  );

  modport slave (
    input  go, in_valid, A, B,
    output in_ready, busy, out, done
  );

endinterface

// File: rtl/mac_mult_stage.sv
// -----------------------------------------------------------------------------
// mac_mult_stage
// First pipeline stage of the MAC: registers the 2*DATA_W-bit product of the
// accepted operand pair together with a valid bit.
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active low
//   valid_i  in   operand pair accepted this cycle
//   a_i      in   multiplicand (DATA_W)
//   b_i      in   multiplier (DATA_W)
//   prod_o   out  registered product (2*DATA_W)
//   valid_o  out  prod_o holds a product still to be accumulated
// SIGNED selects two's complement (1) or unsigned (0) operands.
// -----------------------------------------------------------------------------
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   prod_o,
  output logic                  valid_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] aExt;
  logic [PROD_W-1:0] bExt;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;
  logic              valid_q;

  // Widen both operands to the product width first; the low PROD_W bits of the
  // product of the widened values are correct for both signed and unsigned
  // operands, so a single multiplier serves either mode.
  always_comb begin
    if (SIGNED != 0) begin
      aExt = PROD_W'($signed(a_i));
      bExt = PROD_W'($signed(b_i));
    end else begin
      aExt = PROD_W'(a_i);
      bExt = PROD_W'(b_i);
    end
    prod_d = aExt * bExt;
  end

  // The product register only loads on an accepted pair so bubbles do not
  // toggle it; the valid bit follows the accept every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= prod_d;
      end
    end
  end

  assign prod_o  = prod_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mac_stream_acc.sv
// -----------------------------------------------------------------------------
// mac_stream_acc
// Streaming multiply-accumulate engine. A go pulse in IDLE starts a run that
// accepts ACC_LEN operand pairs over a valid/ready handshake (bubbles allowed),
// multiplies them in mac_mult_stage, accumulates them in a second stage and
// finally presents the sum on out with a one-cycle done pulse.
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active low; aborts a run and clears out
//   bus   mac_stream_acc_if.slave:
//           go, in_valid, A, B          inputs
//           in_ready, busy, out, done   outputs
// Parameters: DATA_W, ACC_LEN (>=1), ACC_W, SIGNED (0 unsigned, 1 signed).
// Build option: define MAC_SATURATE_EN to clamp the accumulator to the ACC_W
// range instead of wrapping modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module mac_stream_acc
  import mac_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ACC_LEN = DEFAULT_ACC_LEN,
  parameter int ACC_W   = defaultAccW(DATA_W, ACC_LEN),
  parameter int SIGNED  = 0
) (
  input  logic            clk,
  input  logic            rst,
  mac_stream_acc_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  macState_t         state_q, state_d;
  logic [CNT_W-1:0]  sampleCnt_q, sampleCnt_d;
  logic              drainCnt_q, drainCnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_q, out_d;
  logic              done_q, done_d;

  logic              accept;
  logic [PROD_W-1:0] prod;
  logic              prodValid;
  logic [ACC_W-1:0]  accSum;

  // in_ready is high throughout ACCUM, so an accept is simply a valid pair
  // arriving while accumulating.
  assign accept = bus.in_valid && (state_q == ACCUM);

  mac_mult_stage #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) uMultStage (
    .clk     (clk),
    .rst     (rst),
    .valid_i (accept),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .prod_o  (prod),
    .valid_o (prodValid)
  );

`ifdef MAC_SATURATE_EN
  // Two guard bits above the wider of accumulator and product keep the sum of
  // an in-range accumulator and one product exact, so the clamp decision can
  // be made on the true value.
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;
  localparam logic [ACC_W-1:0] SIGNED_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SIGNED_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [SUM_W-1:0] accWide;
  logic [SUM_W-1:0] prodWide;
  logic [SUM_W-1:0] sumWide;

  // Saturating second stage: add at full precision, then clamp to the
  // representable ACC_W range for the selected signedness.
  always_comb begin
    if (SIGNED != 0) begin
      accWide  = SUM_W'($signed(acc_q));
      prodWide = SUM_W'($signed(prod));
    end else begin
      accWide  = SUM_W'(acc_q);
      prodWide = SUM_W'(prod);
    end
    sumWide = accWide + prodWide;
    accSum  = sumWide[ACC_W-1:0];
    if (SIGNED != 0) begin
      if ($signed(sumWide) > $signed(SUM_W'($signed(SIGNED_MAX)))) begin
        accSum = SIGNED_MAX;
      end else if ($signed(sumWide) < $signed(SUM_W'($signed(SIGNED_MIN)))) begin
        accSum = SIGNED_MIN;
      end
    end else if (sumWide > SUM_W'({ACC_W{1'b1}})) begin
      accSum = '1;
    end
  end
`else
  logic [ACC_W-1:0] prodExt;

  // Wrapping second stage: extend (or truncate) the product to ACC_W and add
  // modulo 2^ACC_W.
  always_comb begin
    if (SIGNED != 0) begin
      prodExt = ACC_W'($signed(prod));
    end else begin
      prodExt = ACC_W'(prod);
    end
    accSum = acc_q + prodExt;
  end
`endif

  // Next-state logic for the control FSM, the pair counter, the drain timer and
  // the accumulator. The accumulator follows the pipeline valid bit rather than
  // the FSM so the last product still lands during DRAIN. A go in IDLE clears
  // it; the pipeline is empty then, so the clear never races an accumulate.
  always_comb begin
    state_d     = state_q;
    sampleCnt_d = sampleCnt_q;
    drainCnt_d  = drainCnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    done_d      = 1'b0;

    if (prodValid) begin
      acc_d = accSum;
    end

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          acc_d       = '0;
          sampleCnt_d = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (sampleCnt_q == LAST_CNT) begin
            drainCnt_d = 1'b0;
            state_d    = DRAIN;
          end else begin
            sampleCnt_d = sampleCnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        // Two cycles: one for the last product to be registered-and-added,
        // one so DONE sees the settled accumulator.
        if (drainCnt_q) begin
          state_d = DONE;
        end else begin
          drainCnt_d = 1'b1;
        end
      end
      DONE: begin
        out_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any run and clears the held result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      drainCnt_q  <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      drainCnt_q  <= drainCnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready = (state_q == ACCUM);
  assign bus.busy     = (state_q != IDLE);
  assign bus.out      = out_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mac_stream_acc.sv
// -----------------------------------------------------------------------------
// tb_mac_stream_acc
// Directed self-checking bench for mac_stream_acc. Three instances share one
// clock and reset: unsigned 12-bit (dutU), signed 12-bit (dutS) and unsigned
// 10-bit (dutN). A select routes the single stimulus driver to one instance and
// muxes that instance's outputs back for checking.
// -----------------------------------------------------------------------------
module tb_mac_stream_acc;

  logic       clk;
  logic       rst;
  logic       goDrv;
  logic       inValid;
  logic [3:0] aDrv;
  logic [3:0] bDrv;
  int         sel;

  int checks;
  int errors;

  logic        obsReady;
  logic        obsBusy;
  logic        obsDone;
  logic [11:0] obsOut;

  mac_stream_acc_if #(.DATA_W(4), .ACC_W(12)) ifU ();
  mac_stream_acc_if #(.DATA_W(4), .ACC_W(12)) ifS ();
  mac_stream_acc_if #(.DATA_W(4), .ACC_W(10)) ifN ();

  mac_stream_acc #(.DATA_W(4), .ACC_LEN(16), .ACC_W(12), .SIGNED(0)) dutU (
    .clk (clk),
    .rst (rst),
    .bus (ifU.slave)
  );

  mac_stream_acc #(.DATA_W(4), .ACC_LEN(16), .ACC_W(12), .SIGNED(1)) dutS (
    .clk (clk),
    .rst (rst),
    .bus (ifS.slave)
  );

  mac_stream_acc #(.DATA_W(4), .ACC_LEN(16), .ACC_W(10), .SIGNED(0)) dutN (
    .clk (clk),
    .rst (rst),
    .bus (ifN.slave)
  );

  // Route the stimulus to the selected instance only; the others see idle.
  assign ifU.go       = goDrv && (sel == 0);
  assign ifS.go       = goDrv && (sel == 1);
  assign ifN.go       = goDrv && (sel == 2);
  assign ifU.in_valid = inValid && (sel == 0);
  assign ifS.in_valid = inValid && (sel == 1);
  assign ifN.in_valid = inValid && (sel == 2);
  assign ifU.A = aDrv;
  assign ifU.B = bDrv;
  assign ifS.A = aDrv;
  assign ifS.B = bDrv;
  assign ifN.A = aDrv;
  assign ifN.B = bDrv;

  // Observe the selected instance's outputs.
  always_comb begin
    obsReady = ifU.in_ready;
    obsBusy  = ifU.busy;
    obsDone  = ifU.done;
    obsOut   = ifU.out;
    if (sel == 1) begin
      obsReady = ifS.in_ready;
      obsBusy  = ifS.busy;
      obsDone  = ifS.done;
      obsOut   = ifS.out;
    end else if (sel == 2) begin
      obsReady = ifN.in_ready;
      obsBusy  = ifN.busy;
      obsDone  = ifN.done;
      obsOut   = {2'b00, ifN.out};
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One run of 16 pairs: go is raised together with in_valid (go must win),
  // inputs change on the falling edge and outputs are sampled there too.
  // Operands are scrambled whenever in_valid is low. cycles counts rising edges
  // from the go edge up to the cycle in which done is seen.
  task automatic runOnce(input logic [3:0] av, input logic [3:0] bv,
                         input bit bubbles, input int goAgainAt,
                         output bit sawDone, output int cycles,
                         output bit busyAtGo, output bit readyAtGo,
                         output bit busyAtDone);
    int accepted;
    bit phase;
    bit goAgainDone;
    accepted    = 0;
    phase       = 1'b1;
    goAgainDone = 1'b0;
    sawDone     = 1'b0;
    cycles      = 0;
    busyAtGo    = 1'b0;
    readyAtGo   = 1'b0;
    busyAtDone  = 1'b1;
    @(negedge clk);
    goDrv   = 1'b1;
    inValid = 1'b1;
    aDrv    = av;
    bDrv    = bv;
    while (!sawDone && cycles < 200) begin
      @(negedge clk);
      cycles++;
      goDrv = 1'b0;
      if (cycles == 1) begin
        busyAtGo  = obsBusy;
        readyAtGo = obsReady;
      end
      if (obsDone) begin
        sawDone    = 1'b1;
        busyAtDone = obsBusy;
        inValid    = 1'b0;
      end else begin
        inValid = (accepted < 16) && !(bubbles && phase);
        phase   = !phase;
        aDrv    = inValid ? av : 4'($urandom);
        bDrv    = inValid ? bv : 4'($urandom);
        if (inValid && obsReady) begin
          accepted++;
        end
        if (goAgainAt >= 0 && !goAgainDone && accepted == goAgainAt) begin
          goDrv       = 1'b1;
          goAgainDone = 1'b1;
        end
      end
    end
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    goDrv   = 1'b0;
    inValid = 1'b0;
    aDrv    = 4'h0;
    bDrv    = 4'h0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obsReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_in_ready dut%0d got %b want 0", s, obsReady);
      end
      checks++;
      if (obsBusy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy dut%0d got %b want 0", s, obsBusy);
      end
      checks++;
      if (obsDone !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_done dut%0d got %b want 0", s, obsDone);
      end
      checks++;
      if (obsOut !== 12'd0) begin
        errors++;
        $display("[TB] FAIL reset_out dut%0d got %0d want 0", s, obsOut);
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit sawDone, busyAtGo, readyAtGo, busyAtDone;
    int cycles;
    sel = 0;
    runOnce(4'd15, 4'd15, 1'b0, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (busyAtGo !== 1'b1 || readyAtGo !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_after_go busy/ready got %b/%b want 1/1", busyAtGo, readyAtGo);
    end
    checks++;
    if (sawDone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done_seen got %b want 1", sawDone);
    end
    checks++;
    if (cycles != 20) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d want 20", cycles);
    end
    checks++;
    if (obsOut !== 12'd3600) begin
      errors++;
      $display("[TB] FAIL basic_out got %0d want 3600", obsOut);
    end
    checks++;
    if (busyAtDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy_at_done got %b want 0", busyAtDone);
    end
    @(negedge clk);
    checks++;
    if (obsDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done_width got %b want 0", obsDone);
    end
    checks++;
    if (obsOut !== 12'd3600) begin
      errors++;
      $display("[TB] FAIL basic_out_held got %0d want 3600", obsOut);
    end
  endtask

  task automatic test_bubbles();
    bit sawDone, busyAtGo, readyAtGo, busyAtDone;
    int cycles;
    sel = 0;
    runOnce(4'd15, 4'd15, 1'b1, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || cycles != 36) begin
      errors++;
      $display("[TB] FAIL bubbles_latency got %0d (done %b) want 36", cycles, sawDone);
    end
    checks++;
    if (obsOut !== 12'd3600) begin
      errors++;
      $display("[TB] FAIL bubbles_out got %0d want 3600", obsOut);
    end
  endtask

  task automatic test_signed();
    bit sawDone, busyAtGo, readyAtGo, busyAtDone;
    int cycles;
    sel = 1;
    runOnce(4'h8, 4'h7, 1'b0, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || obsOut !== 12'hC80) begin
      errors++;
      $display("[TB] FAIL signed_neg_out got %h (done %b) want c80", obsOut, sawDone);
    end
    runOnce(4'h8, 4'h8, 1'b0, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || obsOut !== 12'h400) begin
      errors++;
      $display("[TB] FAIL signed_pos_out got %h (done %b) want 400", obsOut, sawDone);
    end
  endtask

  task automatic test_go_mid_run();
    bit sawDone, busyAtGo, readyAtGo, busyAtDone;
    int cycles;
    int extraDone;
    sel = 0;
    runOnce(4'd15, 4'd15, 1'b0, 5, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || cycles != 20) begin
      errors++;
      $display("[TB] FAIL gomid_latency got %0d (done %b) want 20", cycles, sawDone);
    end
    checks++;
    if (obsOut !== 12'd3600) begin
      errors++;
      $display("[TB] FAIL gomid_out got %0d want 3600", obsOut);
    end
    extraDone = 0;
    repeat (25) begin
      @(negedge clk);
      if (obsDone === 1'b1) extraDone++;
    end
    checks++;
    if (extraDone != 0) begin
      errors++;
      $display("[TB] FAIL gomid_single_done got %0d extra pulses want 0", extraDone);
    end
  endtask

  task automatic test_reset_mid_run();
    int accepted;
    int doneSeen;
    int guard;
    sel      = 0;
    accepted = 0;
    guard    = 0;
    @(negedge clk);
    goDrv = 1'b1;
    @(negedge clk);
    goDrv   = 1'b0;
    aDrv    = 4'd15;
    bDrv    = 4'd15;
    while (accepted < 8 && guard < 50) begin
      inValid = 1'b1;
      if (obsReady) accepted++;
      @(negedge clk);
      guard++;
    end
    inValid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    doneSeen = 0;
    repeat (30) begin
      @(negedge clk);
      if (obsDone === 1'b1) doneSeen++;
    end
    checks++;
    if (accepted != 8 || doneSeen != 0) begin
      errors++;
      $display("[TB] FAIL rstmid_done got %0d pulses (%0d accepted) want 0", doneSeen, accepted);
    end
    checks++;
    if (obsOut !== 12'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_out got %0d want 0", obsOut);
    end
    checks++;
    if (obsBusy !== 1'b0 || obsReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_idle busy/ready got %b/%b want 0/0", obsBusy, obsReady);
    end
  endtask

  task automatic test_wrap_or_saturate();
    bit sawDone, busyAtGo, readyAtGo, busyAtDone;
    int cycles;
    logic [11:0] want;
`ifdef MAC_SATURATE_EN
    want = 12'd1023;
`else
    want = 12'd528;
`endif
    sel = 2;
    runOnce(4'd15, 4'd15, 1'b0, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || obsOut !== want) begin
      errors++;
      $display("[TB] FAIL narrow_acc_out got %0d (done %b) want %0d", obsOut, sawDone, want);
    end
  endtask

  task automatic test_back_to_back();
    bit sawDone, busyAtGo, readyAtGo, busyAtDone;
    int cycles;
    sel = 0;
    runOnce(4'd1, 4'd1, 1'b0, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || obsOut !== 12'd16) begin
      errors++;
      $display("[TB] FAIL b2b_first_out got %0d (done %b) want 16", obsOut, sawDone);
    end
    runOnce(4'd2, 4'd3, 1'b0, -1, sawDone, cycles, busyAtGo, readyAtGo, busyAtDone);
    checks++;
    if (sawDone !== 1'b1 || cycles != 20) begin
      errors++;
      $display("[TB] FAIL b2b_second_latency got %0d (done %b) want 20", cycles, sawDone);
    end
    checks++;
    if (obsOut !== 12'd96) begin
      errors++;
      $display("[TB] FAIL b2b_second_out got %0d want 96", obsOut);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    sel     = 0;
    rst     = 1'b0;
    goDrv   = 1'b0;
    inValid = 1'b0;
    aDrv    = 4'h0;
    bDrv    = 4'h0;
    test_reset();
    test_basic();
    test_bubbles();
    test_signed();
    test_go_mid_run();
    test_reset_mid_run();
    test_wrap_or_saturate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_stream_acc.md
# mac_stream_acc

Parametrised streaming multiply-accumulate engine. It is the next generation of the team's fixed 4-bit MAC. A `go` pulse starts a run. The block then accepts `ACC_LEN` operand pairs over a valid/ready handshake, tolerates input bubbles, and multiplies and accumulates them through a two-stage pipeline. It reports the sum with a one-cycle `done` pulse and sits between an operand sequencer and result-consuming logic.

## Interface
- `DATA_W`, 4: width of operands `A`, `B`.
- `ACC_LEN`, 16: operand pairs per run, ≥1.
- `ACC_W`, 12: accumulator/result width; default = 2·DATA_W + clog2(ACC_LEN); may be set smaller.
- `SIGNED`, 0: 0 treats operands as unsigned, 1 as two's complement.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rise).
- `go`  in  1  start request, honoured only in IDLE.
- `in_valid`  in  1  operand pair present.
- `A`  in  DATA_W  multiplicand.
- `B`  in  DATA_W  multiplier.
- `in_ready`  out  1  block accepts a pair this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `out`  out  ACC_W  final accumulated sum; held until the next run completes.
- `done`  out  1  one-cycle pulse; `out` is valid in that cycle.

## Operation
- FSM states:
  - IDLE: `go`=1 clears the accumulator and sample counter, then moves to ACCUM.
  - ACCUM: `in_ready`=1. A pair is accepted when `in_valid`&`in_ready`. When the counter reaches ACC_LEN−1 on an accept, the state moves to DRAIN.
  - DRAIN: `in_ready`=0. Waits for the pipeline to empty (2 cycles), then moves to DONE.
  - DONE: registers `out` and pulses `done`, then returns to IDLE.
- Stage 1 registers the product, 2·DATA_W bits, signed or unsigned per `SIGNED`. A valid bit travels with it.
- Stage 2 extends the product to ACC_W bits (sign-extended or zero-extended) and adds it to the accumulator when the valid bit is set.
- Default arithmetic wraps modulo 2^ACC_W.
- `go` outside IDLE is ignored; the current run is not restarted.
- `in_valid`=0 inserts a bubble; the counter, accumulator and result are unaffected.
- `A` and `B` are don't-care when not accepted.
- `go` and `in_valid` in the same IDLE cycle: only `go` is taken. The first accept can occur in the next cycle.
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `out`=0, state IDLE, accumulator, counter and pipeline valid bits all 0.
- Reset mid-run aborts immediately. No `done` is produced and `out` returns to 0.

## Timing
- `go` sampled at edge E0 → `busy` and `in_ready` high after E0.
- The final pair is accepted at edge Ek.
  - Its product is registered at Ek.
  - It is accumulated at Ek+1.
  - `done`=1 and `out` are updated after Ek+3.
  - `busy` falls with `done`; `done` lasts exactly one cycle.
- With no bubbles, a run takes ACC_LEN + 4 cycles from `go` to `done`.
- A new `go` is accepted in the cycle after `done`. Back-to-back runs have one IDLE cycle between them.

## Configuration
- `MAC_SATURATE_EN` defined:
  - Stage 2 clamps to the ACC_W range instead of wrapping. For SIGNED=0 the range is 0..2^ACC_W−1. For SIGNED=1 it is −2^(ACC_W−1)..2^(ACC_W−1)−1.
  - Once clamped, the accumulator stays clamped unless later products move it back inside the range.
- `MAC_SATURATE_EN` undefined: modulo-2^ACC_W wrap, with no extra logic.

## Structure
- Shared package `mac_pkg`:
  - FSM state enum (IDLE, ACCUM, DRAIN, DONE).
  - Default-width constants.
  - A clog2-based function for the default ACC_W.
- One sub-module, `mac_mult_stage`: the registered, signedness-aware multiplier with its valid bit.
- FSM, counter and accumulator live in the top level.

## Test plan
- Defaults; `go`; 16 pairs A=15, B=15 with no bubbles → `done` after 20 cycles, `out`=3600.
- Same pairs with `in_valid` low every other cycle → `out`=3600, `done` 16 cycles later than the bubble-free run.
- SIGNED=1, 16 pairs A=−8, B=7 → `out`=−896 (12'hC80). Then 16 pairs A=−8, B=−8 → `out`=1024.
- `go` pulsed again mid-run → ignored, single `done`, correct sum. `rst`=0 after 8 pairs → `done` never pulses, `out`=0, `busy`=0.
- ACC_W=10, 16 pairs of 15×15:
  - without `MAC_SATURATE_EN` → `out`=528;
  - with it → `out`=1023.
- Back-to-back runs (1×1 sixteen times, then 2×3 sixteen times) → `out`=16, then 96; accumulator cleared between runs.
